// File: rtl/instr_sequencer_pkg.sv
// Shared types and opcode constants for the instruction sequencer.
// Used by the sequencer FSM and by anything that decodes the opcode field.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      WAIT_LO,
      WAIT_HI,
      DONE,
      ERROR
   } state_t;

   localparam logic [2:0] HALT_OP = 3'b111;
   localparam int         OPC_MSB = 15;
   localparam int         OPC_LSB = 13;

   function automatic logic is_halt(input logic [15:0] instr);
      return instr[OPC_MSB:OPC_LSB] == HALT_OP;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the cpu (slave).
interface instr_sequencer_if;

   logic [15:0] cpu_in;
   logic        cpu_load;
   logic        cpu_s;
   logic        cpu_w;
   logic        cpu_N;
   logic        cpu_V;
   logic        cpu_Z;

   modport master (
      output cpu_in, cpu_load, cpu_s,
      input  cpu_w, cpu_N, cpu_V, cpu_Z
   );

   modport slave (
      input  cpu_in, cpu_load, cpu_s,
      output cpu_w, cpu_N, cpu_V, cpu_Z
   );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x 16 RAM, synchronous write, registered read.
// Deliberately has no reset so a program survives a sequencer reset.
module prog_mem #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the cpu one instruction at a time using the
// load / start / wait handshake, with a per-instruction watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for go after reset
// FETCH   | memory read issued at pc (or finish for a zero-length run)
// LOAD    | instruction arrives; present it and pulse cpu_load, or halt
// START   | pulse cpu_s, arm the watchdog
// WAIT_LO | waiting for cpu_w to drop (cpu accepted the start)
// WAIT_HI | waiting for cpu_w to rise (instruction complete)
// DONE    | run finished normally; done held until next go
// ERROR   | watchdog expired; timeout_err held until next go
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int AW      = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                prog_we,
   input  logic [AW-1:0]       prog_addr,
   input  logic [15:0]         prog_wdata,
   input  logic [AW:0]         prog_len,
   input  logic                go,
   instr_sequencer_if.master   cpu,
   output logic [AW-1:0]       pc,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [2:0]          last_flags,
   output logic [AW:0]         instr_count
);

   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [AW:0]     len;
   logic [WW-1:0]   wdog;
   logic [15:0]     rdata;
   logic [AW:0]     count_nxt;

   assign count_nxt = instr_count + CW'(1);

   prog_mem #(.AW(AW)) u_prog_mem (
      .clk   (clk),
      .we    (prog_we && !busy),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         pc           <= '0;
         len          <= '0;
         instr_count  <= '0;
         last_flags   <= '0;
         wdog         <= '0;
         cpu.cpu_in   <= '0;
         cpu.cpu_load <= 1'b0;
         cpu.cpu_s    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         cpu.cpu_load <= 1'b0;
         cpu.cpu_s    <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (go) begin
                  len         <= prog_len;
                  pc          <= '0;
                  instr_count <= '0;
                  done        <= 1'b0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               if (len == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               cpu.cpu_in <= rdata;
               if (is_halt(rdata)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  cpu.cpu_load <= 1'b1;
                  state        <= START;
               end
            end
            START: begin
               cpu.cpu_s <= 1'b1;
               wdog      <= WW'(TIMEOUT - 1);
               state     <= WAIT_LO;
            end
            // Handshake progress wins over the watchdog in the same cycle.
            WAIT_LO: begin
               if (!cpu.cpu_w) begin
                  state <= WAIT_HI;
               end else if (wdog == '0) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ERROR;
               end
               if (wdog != '0) wdog <= wdog - WW'(1);
            end
            WAIT_HI: begin
               if (cpu.cpu_w) begin
                  last_flags  <= {cpu.cpu_N, cpu.cpu_V, cpu.cpu_Z};
                  instr_count <= count_nxt;
                  pc          <= pc + AW'(1);
                  if (count_nxt == len) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     state <= FETCH;
                  end
               end else if (wdog == '0) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ERROR;
               end
               if (wdog != '0) wdog <= wdog - WW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the `cpu` block.
- Holds a small program memory of 16-bit instructions.
- On `go`, presents each instruction on `cpu_in`, pulses `cpu_load`, then pulses `cpu_s`, and waits for the `cpu_w` busy/done handshake before advancing.
- Reports progress, the last captured N/V/Z flags, and a watchdog timeout. This replaces hand-driven load/s sequencing in system-level benches and top-level integration.

Parameters:
- AW, 4, program address width; DEPTH = 2**AW instructions.
- TIMEOUT, 64, maximum cycles allowed from the `cpu_s` pulse until `cpu_w` returns high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- prog_we  input  1  program memory write enable.
- prog_addr  input  AW  program memory write address.
- prog_wdata  input  16  instruction to write.
- prog_len  input  AW+1  number of instructions to run (0..DEPTH); sampled on accepted `go`.
- go  input  1  start request; single-cycle pulse or level.
- cpu_in  output  16  instruction to cpu.
- cpu_load  output  1  cpu instruction-register load.
- cpu_s  output  1  cpu start.
- cpu_w  input  1  cpu wait flag; high = cpu idle.
- cpu_N, cpu_V, cpu_Z  input  1 each  cpu status flags.
- pc  output  AW  index of the current instruction.
- busy  output  1  high while a program is running.
- done  output  1  program completed normally.
- timeout_err  output  1  watchdog expired.
- last_flags  output  3  {N,V,Z} captured at completion of the last instruction.
- instr_count  output  AW+1  instructions completed in the current run.

Behaviour:
- Reset (when reset==0 at a clk edge):
  - State goes to IDLE.
  - pc, instr_count, last_flags, cpu_in all 0.
  - cpu_load, cpu_s, busy, done, timeout_err all 0.
  - Program memory is NOT cleared.
  - Reset mid-run aborts immediately; no further cpu_load/cpu_s pulses are issued.
- Program memory:
  - Synchronous write on prog_we only when busy==0; writes while busy are ignored.
  - Synchronous read, 1-cycle latency.
- States: IDLE, FETCH, LOAD, START, WAIT_LO, WAIT_HI, DONE, ERROR.
- IDLE / DONE / ERROR:
  - go==1 latches prog_len, clears pc, instr_count, done and timeout_err, and sets busy.
  - Next state is FETCH, or DONE on the next cycle if prog_len==0.
  - go while busy is ignored.
- FETCH: issue memory read at pc; go to LOAD.
- LOAD:
  - cpu_in = mem[pc], held stable until the next LOAD.
  - cpu_load=1 for exactly one cycle.
  - If instr[15:13]==3'b111 (HALT): no load pulse; go to DONE.
  - Otherwise go to START.
- START: cpu_s=1 for exactly one cycle; clear the watchdog counter; go to WAIT_LO.
- WAIT_LO: stay until cpu_w==0, then go to WAIT_HI.
- WAIT_HI: when cpu_w==1:
  - last_flags <= {cpu_N,cpu_V,cpu_Z}; instr_count++; pc++.
  - If instr_count+1 == latched length, go to DONE; else go to FETCH.
- Watchdog: counts every cycle in WAIT_LO and WAIT_HI. When it reaches TIMEOUT, go to ERROR: timeout_err=1 (sticky), busy=0, pc frozen.
- DONE: done=1 (level), busy=0, held until the next accepted go or reset.
- Outputs: cpu_load and cpu_s are registered and never asserted in the same cycle.
- Per-instruction overhead: 3 cycles plus cpu execution time.
- pc wrap: with prog_len==DEPTH, the run ends at DONE when pc wraps to 0; execution never re-enters at address 0.

Decomposition:
- Shared package `seq_pkg`:
  - state enum.
  - HALT_OP = 3'b111.
  - Opcode field slice constants OPC_MSB=15, OPC_LSB=13.
- One natural sub-module: `prog_mem`, the DEPTH×16 synchronous-write/synchronous-read RAM.

Test Plan:
- Load mem[0]=16'hD006 (MOV R0,#6), prog_len=1, go -> one cpu_load then one cpu_s pulse; done=1; R0==6; instr_count==1; busy==0.
- Program {D006, D105, A148, D717}, prog_len=4 -> R2==16'h11, R7==16'h17; instr_count==4; pc==4; done=1.
- Program {D006, E000 (HALT), D105}, prog_len=3 -> done after 1 instruction; R1 unchanged; instr_count==1.
- prog_len=0, go -> done=1 within 2 cycles; no cpu_load/cpu_s activity.
- Replace cpu with a stub holding cpu_w=1 -> timeout_err=1 exactly TIMEOUT cycles after the cpu_s pulse; busy=0; done=0.
- Reset (0) asserted during WAIT_HI of instruction 2 -> all outputs 0 next cycle; mem contents intact; re-go reruns from pc 0. prog_we while busy -> memory unchanged.
